// File: rtl/bemf_sequencer.sv
// Back-EMF sweep initiator: per-motor PWM inhibit, settle, two ADC reads, one pipeline issue.
// Optional BEMF_WB_TIMEOUT_EN adds a writeback watchdog and the sticky wb_timeout output.
module bemf_sequencer #(
  parameter logic [15:0] PERIOD_CYCLES = 16'd50000,
  parameter logic [7:0]  SETTLE_CYCLES = 8'd32,
  parameter logic [3:0]  ADC_CH_BASE   = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_req,
  output logic [3:0]  adc_chan,
  input  logic        adc_valid,
  input  logic [9:0]  adc_data,
  output logic [3:0]  pwm_inhibit,
  output logic [9:0]  bemf_adc_h,
  output logic [9:0]  bemf_adc_l,
  output logic [1:0]  mot_sel,
  output logic        in_valid,
  output logic [35:0] bemf_in,
  output logic [35:0] bemf_calib_in,
  input  logic [35:0] bemf_out,
  input  logic [1:0]  mot_sel_out,
  input  logic        out_valid,
  input  logic        calib_we,
  input  logic [1:0]  calib_sel,
  input  logic [35:0] calib_data,
  input  logic [3:0]  bemf_clr,
  output logic [35:0] bemf_0,
  output logic [35:0] bemf_1,
  output logic [35:0] bemf_2,
  output logic [35:0] bemf_3,
  output logic        overrun
`ifdef BEMF_WB_TIMEOUT_EN
  , output logic      wb_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_REQ_H, S_GAP, S_REQ_L, S_ISSUE, S_WAIT_WB
  } state_t;

  state_t       state, state_next;
  logic [15:0]  per_cnt;
  logic [7:0]   settle_cnt;
  logic [1:0]   m;
  logic         req_arm;
  logic [35:0]  acc   [4];
  logic [35:0]  calib [4];
  logic         tick, adc_take, wb_match, wd_expired, wb_done, settle_done;

  assign tick        = (per_cnt == PERIOD_CYCLES - 16'd1);
  // req_arm is low in the first cycle of each request, so a strobe there is ignored.
  assign adc_take    = adc_valid && req_arm;
  assign wb_match    = out_valid && (mot_sel_out == m);
  assign settle_done = ({1'b0, settle_cnt} + 9'd1) >= {1'b0, SETTLE_CYCLES};

`ifdef BEMF_WB_TIMEOUT_EN
  logic [4:0] wd;
  assign wd_expired = (state == S_WAIT_WB) && (wd == 5'd30);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd         <= '0;
      wb_timeout <= 1'b0;
    end else begin
      wd <= (state == S_WAIT_WB) ? wd + 5'd1 : 5'd0;
      if (wd_expired && !wb_match) wb_timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  assign wb_done = wb_match || wd_expired;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (tick && enable) state_next = S_SETTLE;
      S_SETTLE:  if (settle_done) state_next = S_REQ_H;
      S_REQ_H:   if (adc_take) state_next = S_GAP;
      S_GAP:     state_next = S_REQ_L;
      S_REQ_L:   if (adc_take) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT_WB;
      S_WAIT_WB: if (wb_done) state_next = (m == 2'd3) ? S_IDLE : S_SETTLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pwm_inhibit   = '0;
    adc_req       = 1'b0;
    adc_chan      = '0;
    in_valid      = 1'b0;
    bemf_in       = '0;
    bemf_calib_in = '0;
    if (state != S_IDLE) pwm_inhibit = 4'b0001 << m;
    if (state == S_REQ_H || state == S_REQ_L) begin
      adc_req  = 1'b1;
      adc_chan = ADC_CH_BASE + {1'b0, m, 1'b0} + {3'b000, state == S_REQ_L};
    end
    if (state == S_ISSUE) begin
      in_valid      = 1'b1;
      bemf_in       = acc[m];
      bemf_calib_in = calib[m];
    end
  end

  assign mot_sel = m;
  assign bemf_0  = acc[0];
  assign bemf_1  = acc[1];
  assign bemf_2  = acc[2];
  assign bemf_3  = acc[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt    <= '0;
      settle_cnt <= '0;
      m          <= '0;
      req_arm    <= 1'b0;
      bemf_adc_h <= '0;
      bemf_adc_l <= '0;
      overrun    <= 1'b0;
    end else begin
      per_cnt    <= tick ? 16'd0 : per_cnt + 16'd1;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
      req_arm    <= (state == S_REQ_H) || (state == S_REQ_L);
      if (state == S_REQ_H && adc_take) bemf_adc_h <= adc_data;
      if (state == S_REQ_L && adc_take) bemf_adc_l <= adc_data;
      if (state == S_WAIT_WB && wb_done) m <= m + 2'd1;
      if (tick && state != S_IDLE) overrun <= 1'b1;
    end
  end

  // NOTE: the small register banks are reset because their zero state is architectural.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        acc[k]   <= '0;
        calib[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (bemf_clr[k])                                 acc[k] <= '0;
        else if (out_valid && mot_sel_out == 2'(k))      acc[k] <= bemf_out;
        if (calib_we && calib_sel == 2'(k))              calib[k] <= calib_data;
      end
    end
  end

endmodule

// File: tb/tb_bemf_sequencer.sv
// Directed bench for bemf_sequencer with ADC and 4-cycle pipeline responders.
module tb_bemf_sequencer;
  localparam logic [15:0] PER    = 16'd200;
  localparam logic [7:0]  SETTLE = 8'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        adc_req;
  logic [3:0]  adc_chan;
  logic        adc_valid = 1'b0;
  logic [9:0]  adc_data = '0;
  logic [3:0]  pwm_inhibit;
  logic [9:0]  bemf_adc_h, bemf_adc_l;
  logic [1:0]  mot_sel;
  logic        in_valid;
  logic [35:0] bemf_in, bemf_calib_in;
  logic [35:0] bemf_out = '0;
  logic [1:0]  mot_sel_out = '0;
  logic        out_valid = 1'b0;
  logic        calib_we = 1'b0;
  logic [1:0]  calib_sel = '0;
  logic [35:0] calib_data = '0;
  logic [3:0]  bemf_clr = '0;
  logic [35:0] bemf_0, bemf_1, bemf_2, bemf_3;
  logic        overrun;
`ifdef BEMF_WB_TIMEOUT_EN
  logic        wb_timeout;
`endif

  bemf_sequencer #(.PERIOD_CYCLES(PER), .SETTLE_CYCLES(SETTLE), .ADC_CH_BASE(4'd0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_req(adc_req), .adc_chan(adc_chan), .adc_valid(adc_valid), .adc_data(adc_data),
    .pwm_inhibit(pwm_inhibit), .bemf_adc_h(bemf_adc_h), .bemf_adc_l(bemf_adc_l),
    .mot_sel(mot_sel), .in_valid(in_valid), .bemf_in(bemf_in), .bemf_calib_in(bemf_calib_in),
    .bemf_out(bemf_out), .mot_sel_out(mot_sel_out), .out_valid(out_valid),
    .calib_we(calib_we), .calib_sel(calib_sel), .calib_data(calib_data), .bemf_clr(bemf_clr),
    .bemf_0(bemf_0), .bemf_1(bemf_1), .bemf_2(bemf_2), .bemf_3(bemf_3),
    .overrun(overrun)
`ifdef BEMF_WB_TIMEOUT_EN
    , .wb_timeout(wb_timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mot;
    logic [9:0]  h, l;
    logic [35:0] bin, cin;
  } txn_t;

  txn_t        txq[$];
  int          checks = 0, failures = 0;
  int          adc_lat = 3, adc_cnt = 0, drop_motor = -1, onehot_bad = 0;
  bit          clr_on_m1 = 1'b0, manual = 1'b0;
  logic        pv[4] = '{default: 1'b0};
  logic [1:0]  pm[4] = '{default: 2'd0};
  logic [35:0] pd[4] = '{default: 36'd0};

  // ADC responder: strobes chan*10 after adc_lat cycles of request.
  always @(negedge clk) begin
    if (adc_req && !adc_valid) begin
      adc_cnt++;
      if (adc_cnt >= adc_lat) begin
        adc_valid = 1'b1;
        adc_data  = 10'({6'd0, adc_chan} * 10'd10);
      end
    end else begin
      adc_valid = 1'b0;
      adc_cnt   = 0;
    end
  end

  // Pipeline responder: returns bemf_in+1 four cycles after issue.
  always @(negedge clk) begin
    if (!manual) begin
      out_valid   = pv[3] && (int'(pm[3]) != drop_motor);
      mot_sel_out = pm[3];
      bemf_out    = pd[3];
      bemf_clr    = (clr_on_m1 && out_valid && pm[3] == 2'd1) ? 4'b0010 : 4'b0000;
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1]; pm[i] = pm[i-1]; pd[i] = pd[i-1];
      end
      pv[0] = in_valid; pm[0] = mot_sel; pd[0] = bemf_in + 36'd1;
    end
  end

  always @(negedge clk) begin
    txn_t t;
    if (in_valid) begin
      t.mot = mot_sel; t.h = bemf_adc_h; t.l = bemf_adc_l; t.bin = bemf_in; t.cin = bemf_calib_in;
      txq.push_back(t);
    end
    if (!$onehot0(pwm_inhibit)) onehot_bad++;
  end

  task automatic wait_txn(input int n, input int budget, output bit ok);
    int c = 0;
    while (txq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (txq.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (adc_req !== 1'b0) begin failures++; $display("FAIL reset_adc_req got=%0b exp=0", adc_req); end
    checks++; if (pwm_inhibit !== 4'd0) begin failures++; $display("FAIL reset_pwm got=%b exp=0000", pwm_inhibit); end
    checks++; if (in_valid !== 1'b0 || mot_sel !== 2'd0) begin failures++; $display("FAIL reset_issue got=%0b/%0d exp=0/0", in_valid, mot_sel); end
    checks++; if ((bemf_0 | bemf_1 | bemf_2 | bemf_3) !== 36'd0) begin failures++; $display("FAIL reset_acc got=%h exp=0", bemf_0 | bemf_1 | bemf_2 | bemf_3); end
    checks++; if (overrun !== 1'b0 || bemf_adc_h !== 10'd0 || bemf_adc_l !== 10'd0) begin failures++; $display("FAIL reset_misc got=%0b/%0d/%0d exp=0/0/0", overrun, bemf_adc_h, bemf_adc_l); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_calib_write();
    calib_we = 1'b1; calib_sel = 2'd2; calib_data = 36'd7;
    @(negedge clk);
    calib_we = 1'b0; calib_sel = 2'd0; calib_data = '0;
  endtask

  task automatic test_sweep();
    bit ok;
    txq.delete();
    enable = 1'b1;
    wait_txn(4, 600, ok);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL sweep_count got=%0d exp=4", txq.size()); end
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      checks++; if (txq[i].mot !== 2'(i)) begin failures++; $display("FAIL sweep_mot[%0d] got=%0d exp=%0d", i, txq[i].mot, i); end
      checks++; if (txq[i].h !== 10'(20*i) || txq[i].l !== 10'(20*i+10)) begin failures++; $display("FAIL sweep_adc[%0d] got=%0d/%0d exp=%0d/%0d", i, txq[i].h, txq[i].l, 20*i, 20*i+10); end
      checks++; if (txq[i].bin !== 36'd0) begin failures++; $display("FAIL sweep_bin[%0d] got=%0d exp=0", i, txq[i].bin); end
      checks++; if (txq[i].cin !== ((i == 2) ? 36'd7 : 36'd0)) begin failures++; $display("FAIL sweep_calib[%0d] got=%0d exp=%0d", i, txq[i].cin, (i == 2) ? 7 : 0); end
    end
    checks++; if (bemf_0 !== 36'd1 || bemf_1 !== 36'd1 || bemf_2 !== 36'd1 || bemf_3 !== 36'd1) begin failures++; $display("FAIL sweep_acc got=%0d,%0d,%0d,%0d exp=1,1,1,1", bemf_0, bemf_1, bemf_2, bemf_3); end
    checks++; if (onehot_bad !== 0) begin failures++; $display("FAIL sweep_onehot got=%0d exp=0", onehot_bad); end
    checks++; if (pwm_inhibit !== 4'd0 || overrun !== 1'b0) begin failures++; $display("FAIL sweep_idle got=%b/%0b exp=0000/0", pwm_inhibit, overrun); end
  endtask

  task automatic test_clear_writeback();
    bit ok;
    txq.delete();
    clr_on_m1 = 1'b1;
    enable = 1'b1;
    wait_txn(4, 600, ok);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    clr_on_m1 = 1'b0;
    checks++; if (!ok || txq[1].bin !== 36'd1) begin failures++; $display("FAIL clr_bin1 got=%0d exp=1", ok ? txq[1].bin : 36'd0); end
    checks++; if (bemf_1 !== 36'd0) begin failures++; $display("FAIL clr_acc1 got=%0d exp=0", bemf_1); end
    checks++; if (bemf_0 !== 36'd2 || bemf_2 !== 36'd2 || bemf_3 !== 36'd2) begin failures++; $display("FAIL clr_others got=%0d,%0d,%0d exp=2,2,2", bemf_0, bemf_2, bemf_3); end
  endtask

  task automatic test_direct_writeback();
    manual = 1'b1;
    out_valid = 1'b0; bemf_clr = 4'b0001;
    @(negedge clk);
    bemf_clr = 4'b0000; out_valid = 1'b1; mot_sel_out = 2'd0; bemf_out = 36'h8_0000_0005;
    @(negedge clk);
    bemf_clr = 4'b1000; mot_sel_out = 2'd3; bemf_out = 36'd55;
    @(negedge clk);
    bemf_clr = 4'b0000; mot_sel_out = 2'd2; bemf_out = 36'h1_2345_6789;
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    manual = 1'b0;
    checks++; if (bemf_0 !== 36'h8_0000_0005) begin failures++; $display("FAIL wb_after_clr got=%h exp=800000005", bemf_0); end
    checks++; if (bemf_3 !== 36'd0) begin failures++; $display("FAIL clr_priority got=%0d exp=0", bemf_3); end
    checks++; if (bemf_2 !== 36'h1_2345_6789) begin failures++; $display("FAIL wb_idle_idx got=%h exp=123456789", bemf_2); end
  endtask

  task automatic test_overrun();
    bit ok;
    txq.delete();
    adc_lat = 60;
    enable = 1'b1;
    wait_txn(4, 2000, ok);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    adc_lat = 3;
    checks++; if (!ok) begin failures++; $display("FAIL ovr_count got=%0d exp=4", txq.size()); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
    for (int i = 0; i < 4 && i < txq.size(); i++) begin
      checks++; if (txq[i].mot !== 2'(i)) begin failures++; $display("FAIL ovr_mot[%0d] got=%0d exp=%0d", i, txq[i].mot, i); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit ok;
    int c = 0, bad = 0;
    enable = 1'b1;
    while (!(adc_req && adc_chan == 4'd5) && c < 600) begin
      @(negedge clk);
      c++;
    end
    checks++; if (pwm_inhibit !== 4'b0100) begin failures++; $display("FAIL rst_reach_reql got=%b exp=0100", pwm_inhibit); end
    reset = 1'b1;
    #1;
    checks++; if (adc_req !== 1'b0 || pwm_inhibit !== 4'd0 || in_valid !== 1'b0) begin failures++; $display("FAIL rst_async got=%0b/%b/%0b exp=0/0000/0", adc_req, pwm_inhibit, in_valid); end
    checks++; if (overrun !== 1'b0 || (bemf_0 | bemf_2) !== 36'd0) begin failures++; $display("FAIL rst_state got=%0b/%h exp=0/0", overrun, bemf_0 | bemf_2); end
    @(negedge clk);
    reset = 1'b0;
    txq.delete();
    repeat (150) begin
      @(negedge clk);
      if (adc_req || pwm_inhibit != 4'd0 || in_valid) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_idle got=%0d exp=0", bad); end
    wait_txn(4, 600, ok);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (!ok || txq[0].mot !== 2'd0 || txq[0].bin !== 36'd0 || txq[2].cin !== 36'd0) begin failures++; $display("FAIL rst_restart got=%0d exp=motor0", ok ? txq[0].mot : 2'd3); end
    checks++; if (bemf_0 !== 36'd1 || bemf_1 !== 36'd1 || bemf_2 !== 36'd1 || bemf_3 !== 36'd1) begin failures++; $display("FAIL rst_acc got=%0d,%0d,%0d,%0d exp=1,1,1,1", bemf_0, bemf_1, bemf_2, bemf_3); end
  endtask

`ifdef BEMF_WB_TIMEOUT_EN
  task automatic test_wb_timeout();
    bit ok;
    int c = 0;
    txq.delete();
    drop_motor = 1;
    checks++; if (wb_timeout !== 1'b0) begin failures++; $display("FAIL to_initial got=%0b exp=0", wb_timeout); end
    enable = 1'b1;
    wait_txn(2, 600, ok);
    while (!wb_timeout && c < 60) begin
      @(negedge clk);
      c++;
    end
    checks++; if (!ok || !wb_timeout || c < 29 || c > 33) begin failures++; $display("FAIL to_latency got=%0d exp=31", c); end
    wait_txn(4, 300, ok);
    enable = 1'b0;
    repeat (20) @(negedge clk);
    drop_motor = -1;
    checks++; if (!ok || txq[2].mot !== 2'd2 || txq[3].mot !== 2'd3) begin failures++; $display("FAIL to_continue got=%0d exp=4", txq.size()); end
    checks++; if (bemf_1 !== 36'd1) begin failures++; $display("FAIL to_acc1 got=%0d exp=1", bemf_1); end
    checks++; if (bemf_0 !== 36'd2 || bemf_2 !== 36'd2 || bemf_3 !== 36'd2) begin failures++; $display("FAIL to_others got=%0d,%0d,%0d exp=2,2,2", bemf_0, bemf_2, bemf_3); end
  endtask
`endif

  initial begin
    test_reset();
    test_calib_write();
    test_sweep();
    test_clear_writeback();
    test_direct_writeback();
    test_overrun();
    test_reset_mid_sweep();
`ifdef BEMF_WB_TIMEOUT_EN
    test_wb_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/bemf_sequencer.md
Name: bemf_sequencer

Overview:
- Initiator side of the back-EMF update pipeline.
- Periodically sweeps all four motors. Per motor: inhibits PWM, waits for the motor to settle, reads the high-side and low-side ADC channels, then issues one transaction to the update pipeline.
- Owns the per-motor 36-bit integrator bank and the calibration registers. Accepts pipeline writebacks and exposes the integrated values to the register interface.

Parameters:
- PERIOD_CYCLES, 16'd50000, clk cycles between sweep starts (must be ≥ 2)
- SETTLE_CYCLES, 8'd32, clk cycles of PWM inhibit before the first ADC request for a motor (0 = request on the next cycle)
- ADC_CH_BASE, 4'd0, ADC channel of motor 0 high side; motor m high = base+2m, low = base+2m+1 (mod 16)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  allows sweeps to start; deasserting stops new sweeps, the current sweep completes
- adc_req  out  1  ADC conversion request, held until adc_valid
- adc_chan  out  4  ADC channel, stable while adc_req=1
- adc_valid  in  1  one-cycle conversion-done strobe
- adc_data  in  10  conversion result, valid with adc_valid
- pwm_inhibit  out  4  one-hot; bit m high while motor m is being measured
- bemf_adc_h  out  10  registered high-side sample to pipeline
- bemf_adc_l  out  10  registered low-side sample
- mot_sel  out  2  motor index of the issued transaction
- in_valid  out  1  one-cycle transaction strobe
- bemf_in  out  36  acc[mot_sel], valid with in_valid
- bemf_calib_in  out  36  calib[mot_sel], valid with in_valid
- bemf_out  in  36  pipeline result
- mot_sel_out  in  2  motor index of the result
- out_valid  in  1  result strobe
- calib_we  in  1  calibration write strobe
- calib_sel  in  2  calibration register index
- calib_data  in  36  calibration value
- bemf_clr  in  4  per-motor accumulator clear, level-sensitive
- bemf_0..bemf_3  out  36 each  accumulator contents
- overrun  out  1  sticky; set when a period tick arrives while a sweep is busy; cleared only by reset

Behaviour:
- Reset values:
  - All outputs 0.
  - acc[] and calib[] = 0.
  - Period counter = 0.
  - FSM in IDLE.
- Period counter:
  - Free-runs 0..PERIOD_CYCLES-1 and raises tick at wrap.
  - A tick in IDLE with enable=1 starts a sweep at motor 0.
  - A tick outside IDLE sets overrun and is dropped.
- FSM:
  - IDLE: wait for a qualifying tick.
  - SETTLE: pwm_inhibit[m]=1; count SETTLE_CYCLES, then go to REQ_H.
  - REQ_H: adc_req=1, adc_chan=high channel. On adc_valid, latch bemf_adc_h and go to REQ_L.
  - REQ_L: same as REQ_H for the low channel; latch bemf_adc_l. adc_req deasserts for at least 1 cycle between REQ_H and REQ_L.
  - ISSUE: in_valid=1 for exactly one cycle, with mot_sel=m, bemf_in=acc[m], bemf_calib_in=calib[m].
  - WAIT_WB: wait for out_valid with mot_sel_out==m. Then release pwm_inhibit[m]. If m==3 go to IDLE, else m+1 and go to SETTLE.
- adc_valid is ignored outside REQ_H/REQ_L, and in the same cycle adc_req first rises.
- Writeback:
  - On out_valid, acc[mot_sel_out] <= bemf_out. This applies even when mot_sel_out≠m; only a matching index advances the FSM.
  - bemf_clr[k] forces acc[k]=0 and has priority over a same-cycle writeback to k.
  - A writeback arriving in the cycle after a clear is accepted normally.
- calib_we updates calib[calib_sel] on the next edge. A write in the same cycle as ISSUE for that motor presents the old value.
- Issue-to-writeback latency is 4 cycles with the current pipeline; the FSM does not depend on it.
- Reset mid-sweep:
  - All outputs drop immediately (async), including pwm_inhibit and adc_req.
  - No partial transaction resumes after reset.
- Arithmetic: none beyond storage; all 36-bit values are passed through unmodified.

Optional Feature:
- Macro: BEMF_WB_TIMEOUT_EN.
- Defined:
  - WAIT_WB carries a 5-bit watchdog.
  - If 31 cycles pass without a matching out_valid, the motor is skipped: acc[m] is unchanged, pwm_inhibit is released, and the FSM advances as on a normal writeback.
  - A sticky output wb_timeout (1 bit, reset 0) is added.
- Undefined: WAIT_WB waits indefinitely and the wb_timeout port does not exist.

Test Plan:
- PERIOD_CYCLES=200, SETTLE_CYCLES=4, ADC model answering 3 cycles after req with adc_data=chan*10, pipeline model returning bemf_in+1 after 4 cycles -> one sweep issues motors 0,1,2,3 in order; bemf_adc_h/l=0/10, 20/30, 40/50, 60/70; bemf_0..3=1; pwm_inhibit one-hot, never two bits high.
- calib_we sel=2 data=36'd7 before sweep -> bemf_calib_in=7 only on mot_sel=2 transaction, 0 on others.
- bemf_clr=4'b0010 asserted in same cycle as out_valid for motor 1 -> bemf_1=0 afterwards; other accumulators updated.
- PERIOD_CYCLES=20 with ADC latency 10 -> overrun=1 after first tick during sweep; sweep still completes all four motors.
- Assert reset during REQ_L of motor 2 -> adc_req, pwm_inhibit, in_valid=0 the same cycle; after release, FSM idle until next tick, acc cleared.
- BEMF_WB_TIMEOUT_EN defined, pipeline never returns motor 1 -> wb_timeout=1 31 cycles after ISSUE; motors 2,3 still issued; bemf_1 unchanged.
